// File: rtl/cache_arbiter.sv
// Two-way arbiter sharing one L2 port between the instruction and data caches.
// Round-robin on ties, direct hand-over on ack when the other side waits, watchdog abort.
module cache_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         icache_cyc,
    input  logic         icache_stb,
    input  logic         icache_we,
    input  logic [15:0]  icache_adr,
    input  logic [127:0] icache_wdata,
    input  logic         dcache_cyc,
    input  logic         dcache_stb,
    input  logic         dcache_we,
    input  logic [15:0]  dcache_adr,
    input  logic [127:0] dcache_wdata,
    input  logic         l2_ack,
    input  logic [127:0] l2_rdata,
    output logic         l2_cyc,
    output logic         l2_stb,
    output logic         l2_we,
    output logic [15:0]  l2_adr,
    output logic [127:0] l2_wdata,
    output logic         icache_ack,
    output logic         dcache_ack,
    output logic         icache_err,
    output logic         dcache_err,
    output logic [127:0] rdata,
    output logic         grant_i,
    output logic         grant_d
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_e;

    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

    state_e     state_q;
    logic       last_grant_q;  // 0 = I was served last, 1 = D
    logic [7:0] wdog_q;

    logic req_i;
    logic req_d;
    logic in_i;
    logic in_d;
    logic wdog_hit;

    assign req_i    = icache_cyc & icache_stb;
    assign req_d    = dcache_cyc & dcache_stb;
    assign in_i     = (state_q == GRANT_I);
    assign in_d     = (state_q == GRANT_D);
    assign wdog_hit = (wdog_q == WDOG_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            wdog_q       <= 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    wdog_q <= 8'd0;
                    if (req_i && (!req_d || last_grant_q)) begin
                        state_q <= GRANT_I;
                    end else if (req_d) begin
                        state_q <= GRANT_D;
                    end
                end
                GRANT_I: begin
                    // Ack takes precedence over both abort and timeout.
                    if (l2_ack) begin
                        last_grant_q <= 1'b0;
                        wdog_q       <= 8'd0;
                        state_q      <= req_d ? GRANT_D : IDLE;
                    end else if (!icache_cyc) begin
                        state_q <= IDLE;
                    end else if (wdog_hit) begin
                        last_grant_q <= 1'b0;
                        state_q      <= IDLE;
                    end else if (wdog_q != 8'hFF) begin
                        wdog_q <= wdog_q + 8'd1;
                    end
                end
                GRANT_D: begin
                    if (l2_ack) begin
                        last_grant_q <= 1'b1;
                        wdog_q       <= 8'd0;
                        state_q      <= req_i ? GRANT_I : IDLE;
                    end else if (!dcache_cyc) begin
                        state_q <= IDLE;
                    end else if (wdog_hit) begin
                        last_grant_q <= 1'b1;
                        state_q      <= IDLE;
                    end else if (wdog_q != 8'hFF) begin
                        wdog_q <= wdog_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    wdog_q  <= 8'd0;
                end
            endcase
        end
    end

    // The granted side's bus is passed straight through; IDLE drives zeros.
    always_comb begin
        l2_cyc   = 1'b0;
        l2_stb   = 1'b0;
        l2_we    = 1'b0;
        l2_adr   = '0;
        l2_wdata = '0;
        if (in_i) begin
            l2_cyc   = icache_cyc;
            l2_stb   = icache_stb;
            l2_we    = icache_we;
            l2_adr   = icache_adr;
            l2_wdata = icache_wdata;
        end else if (in_d) begin
            l2_cyc   = dcache_cyc;
            l2_stb   = dcache_stb;
            l2_we    = dcache_we;
            l2_adr   = dcache_adr;
            l2_wdata = dcache_wdata;
        end
    end

    assign icache_ack = in_i & l2_ack;
    assign dcache_ack = in_d & l2_ack;
    assign icache_err = in_i & ~l2_ack & icache_cyc & wdog_hit;
    assign dcache_err = in_d & ~l2_ack & dcache_cyc & wdog_hit;
    assign rdata      = l2_rdata;
    assign grant_i    = in_i;
    assign grant_d    = in_d;

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, giving the number of cycles without ack before a granted transaction is aborted; legal range 1..255.
REQ-002 SHALL have the following ports, in this order:
  clk  input  1  single clock, all state on rising edge
  reset_n  input  1  reset, asynchronous, active-low
  icache_cyc  input  1  instruction-side bus cycle
  icache_stb  input  1  instruction-side strobe
  icache_we  input  1  instruction-side write enable
  icache_adr  input  16  instruction-side line address
  icache_wdata  input  128  instruction-side write line
  dcache_cyc  input  1  data-side bus cycle
  dcache_stb  input  1  data-side strobe
  dcache_we  input  1  data-side write enable
  dcache_adr  input  16  data-side line address
  dcache_wdata  input  128  data-side write line
  l2_ack  input  1  L2 transfer complete
  l2_rdata  input  128  L2 read line
  l2_cyc  output  1  to L2
  l2_stb  output  1  to L2
  l2_we  output  1  to L2
  l2_adr  output  16  to L2
  l2_wdata  output  128  to L2
  icache_ack  output  1  instruction-side ack
  dcache_ack  output  1  data-side ack
  icache_err  output  1  instruction-side timeout, one-cycle pulse
  dcache_err  output  1  data-side timeout, one-cycle pulse
  rdata  output  128  read line broadcast to both sides
  grant_i  output  1  instruction side owns L2
  grant_d  output  1  data side owns L2

Function
REQ-003 SHALL define req_i = icache_cyc & icache_stb and req_d = dcache_cyc & dcache_stb.
REQ-004 SHALL implement the states IDLE, GRANT_I and GRANT_D, plus a 1-bit last_grant register (0 = I, 1 = D) and an 8-bit watchdog counter.
REQ-005 IDLE with exactly one request pending SHALL move to that side's GRANT state on the next edge.
REQ-006 IDLE with both requests pending SHALL grant the side not equal to last_grant.
REQ-007 IDLE with no request SHALL stay in IDLE.
REQ-008 Grant latency SHALL be exactly 1 cycle from the first request cycle seen in IDLE.
REQ-009 In GRANT_x, l2_cyc, l2_stb, l2_we, l2_adr and l2_wdata SHALL equal requester x's inputs combinationally.
REQ-010 In GRANT_x, x_ack SHALL equal l2_ack combinationally, and the other side's ack SHALL be 0.
REQ-011 In IDLE, all l2_* outputs and both acks SHALL be 0, and any l2_ack SHALL be ignored.
REQ-012 rdata SHALL equal l2_rdata in every state.
REQ-013 grant_i and grant_d SHALL be 1 exactly in GRANT_I and GRANT_D respectively; they SHALL never both be 1.
REQ-014 On l2_ack in GRANT_x, last_grant SHALL be set to x.
REQ-015 On l2_ack in GRANT_x, the next state SHALL be GRANT_other if the other side is requesting in that same cycle, else IDLE.
REQ-016 After a completed transfer, a re-request from the same side SHALL always pass through IDLE (one bubble cycle).
REQ-017 If x drops its cyc in GRANT_x before ack (abort), the state SHALL return to IDLE next edge with last_grant unchanged and no err pulse.
REQ-018 The watchdog counter SHALL clear to 0 on every transition into a GRANT state.
REQ-019 The watchdog counter SHALL increment each GRANT cycle that has no l2_ack, saturating at 255.
REQ-020 If the watchdog counter equals TIMEOUT-1 and l2_ack is 0, then x_err SHALL pulse for that cycle, x_ack SHALL stay 0, last_grant SHALL be set to x, and the state SHALL go to IDLE.
REQ-021 If l2_ack and the timeout condition occur in the same cycle, ack SHALL win and err SHALL stay 0.
REQ-022 No transfer SHALL ever be acknowledged to a side that is not granted.

Reset
REQ-023 reset_n low SHALL force, asynchronously, state = IDLE, last_grant = 1 (so the first tie goes to I), watchdog = 0, and all outputs except rdata to 0.
REQ-024 Reset asserted mid-transaction SHALL drop l2_cyc immediately, and no ack or err SHALL be generated for the aborted transfer.
REQ-025 After reset_n rises, arbitration SHALL start on the first rising clk edge.

Verification
REQ-026 Single I read: req_i at cycle 0, l2_ack at cycle 3 -> grant_i = 1 on cycles 1-3; icache_ack = 1 on cycle 3 only; state IDLE at cycle 4; dcache_ack = 0 throughout.
REQ-027 Tie after reset: req_i and req_d both at cycle 0 -> GRANT_I; on I's ack with req_d still held -> GRANT_D on the next cycle with no IDLE cycle; D's adr and wdata appear on l2_*.
REQ-028 Fairness: both sides requesting continuously, L2 acks 2 cycles after each grant -> grants alternate I, D, I, D; neither side gets two grants in a row.
REQ-029 Timeout with TIMEOUT = 4: grant D, never ack -> dcache_err pulses on the 4th grant cycle; state IDLE next cycle; a later tie goes to I.
REQ-030 Abort and reset: I granted, icache_cyc dropped before ack -> IDLE, no err. Separately, reset_n low during GRANT_D -> l2_cyc = 0 with no clock edge; no ack follows.
